// File: rtl/z80_bus_target_if.sv
// Z80 target-side bus bundle: CPU strobes/data plus the req/ack backend port.
// The slave modport is the responder's view; master is the CPU/backend side.
interface z80_bus_target_if;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [15:0] A;
    logic [7:0]  dout;
    logic        wait_n;
    logic [7:0]  di;
    logic        bus_req;
    logic        bus_we;
    logic        bus_io;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic        err;

    modport slave (
        input  m1_n, mreq_n, iorq_n, rd_n, wr_n, A, dout, bus_ack, bus_rdata,
        output wait_n, di, bus_req, bus_we, bus_io, bus_addr, bus_wdata, err
    );

    modport master (
        output m1_n, mreq_n, iorq_n, rd_n, wr_n, A, dout, bus_ack, bus_rdata,
        input  wait_n, di, bus_req, bus_we, bus_io, bus_addr, bus_wdata, err
    );
endinterface

// File: rtl/z80_bus_target.sv
// Z80 bus responder: turns CPU strobes into one req/ack backend transaction,
// stretching the CPU with wait_n; answers INTA with a fixed vector.
module z80_bus_target #(
    parameter logic [7:0]  INT_VECTOR = 8'hFF,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset,
    z80_bus_target_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TMO_CNT = TIMEOUT[7:0];

    state_t      state, state_nxt;
    logic        act, inta, strobe, prev, start, ack, tmo;
    logic        wait_c;
    logic [7:0]  cnt;
    logic [7:0]  di_q, wdata_q;
    logic [15:0] addr_q;
    logic        req_q, we_q, io_q, err_q;

    assign act    = (!bus.rd_n || !bus.wr_n) && (!bus.mreq_n || !bus.iorq_n);
    assign inta   = !bus.m1_n && !bus.iorq_n;
    assign strobe = act || inta;
    assign start  = strobe && !prev && (state == IDLE);
    assign ack    = bus.bus_ack && req_q;
    assign tmo    = (TIMEOUT != 0) && (cnt == TMO_CNT);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)       state_nxt = inta ? DONE : BUSY;
            BUSY: if (ack || tmo)  state_nxt = strobe ? DONE : IDLE;
            DONE: if (!strobe)     state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wait_c = 1'b1;
        if (start || (state == BUSY && strobe)) wait_c = 1'b0;
    end

    // prev resets high so a cycle already in flight at release is not taken
    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= 1'b1;
            cnt     <= 8'd0;
            di_q    <= 8'h00;
            wdata_q <= 8'h00;
            addr_q  <= 16'h0000;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prev  <= strobe;
            err_q <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (inta) begin
                        di_q <= INT_VECTOR;
                    end else begin
                        addr_q  <= bus.A;
                        wdata_q <= bus.dout;
                        we_q    <= !bus.wr_n;
                        io_q    <= !bus.iorq_n;
                        req_q   <= 1'b1;
                        cnt     <= 8'd0;
                    end
                end
                BUSY: begin
                    // an abandoned access (strobe gone) leaves di untouched
                    if (ack) begin
                        req_q <= 1'b0;
                        if (!we_q && strobe) di_q <= bus.bus_rdata;
                    end else if (tmo) begin
                        req_q <= 1'b0;
                        err_q <= 1'b1;
                        if (strobe) di_q <= 8'hFF;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wait_n    = wait_c;
    assign bus.di        = di_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_io    = io_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_z80_bus_target.sv
// Directed bench for z80_bus_target (INT_VECTOR=E7, TIMEOUT=4): reads, writes,
// INTA, timeout, refresh and reset behaviour with hand-computed expectations.
module tb_z80_bus_target;
    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    z80_bus_target_if bus ();

    z80_bus_target #(.INT_VECTOR(8'hE7), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes_idle();
        bus.m1_n   = 1'b1;
        bus.mreq_n = 1'b1;
        bus.iorq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
    endtask

    // Runs one CPU access starting at detection cycle N (caller is just past an
    // edge, block idle). ack_cyc = BUSY cycle (1-based) carrying the ack, 0 = never.
    // Returns with the block in DONE (strobes still held), sampled mid-cycle.
    task automatic access(input bit io, input bit wr, input logic [15:0] a,
                          input logic [7:0] d, input int ack_cyc,
                          input logic [7:0] rdata, output int waits, output int errs);
        bit done = 0;
        bus.A         = a;
        bus.dout      = d;
        bus.bus_rdata = rdata;
        bus.mreq_n    = io;
        bus.iorq_n    = !io;
        bus.rd_n      = wr;
        bus.wr_n      = !wr;
        waits = 0;
        errs  = 0;
        for (int k = 0; k < 24; k++) begin
            bus.bus_ack = (k != 0) && (k == ack_cyc);
            #1;
            errs += int'(bus.err);
            if (k == 1) begin
                chk("req_n1",  32'(bus.bus_req),  32'd1);
                chk("io_n1",   32'(bus.bus_io),   32'(io));
                chk("we_n1",   32'(bus.bus_we),   32'(wr));
                chk("addr_n1", 32'(bus.bus_addr), 32'(a));
                if (wr) chk("wdata_n1", 32'(bus.bus_wdata), 32'(d));
            end
            if (bus.wait_n) begin
                done = 1;
                break;
            end
            waits++;
            cyc();
        end
        bus.bus_ack = 1'b0;
        if (!done) chk("wait_bound", 32'd0, 32'd1);
    endtask

    int waits, errs;

    initial begin
        strobes_idle();
        bus.A = 16'h0; bus.dout = 8'h0; bus.bus_ack = 1'b0; bus.bus_rdata = 8'h0;
        reset = 1'b1;
        cyc(); cyc();
        #1;
        chk("rst_wait",  32'(bus.wait_n),    32'd1);
        chk("rst_di",    32'(bus.di),        32'h00);
        chk("rst_req",   32'(bus.bus_req),   32'd0);
        chk("rst_we",    32'(bus.bus_we),    32'd0);
        chk("rst_io",    32'(bus.bus_io),    32'd0);
        chk("rst_addr",  32'(bus.bus_addr),  32'h0);
        chk("rst_wdata", 32'(bus.bus_wdata), 32'h0);
        chk("rst_err",   32'(bus.err),       32'd0);
        reset = 1'b0;
        cyc();

        // memory read, ack on 3rd BUSY cycle
        access(1'b0, 1'b0, 16'h1234, 8'h00, 3, 8'h5A, waits, errs);
        chk("rd_waits", 32'(waits), 32'd4);
        chk("rd_di",    32'(bus.di), 32'h5A);
        chk("rd_req",   32'(bus.bus_req), 32'd0);
        chk("rd_err",   32'(errs), 32'd0);
        strobes_idle();
        cyc(); #1;
        chk("rd_idle_wait", 32'(bus.wait_n), 32'd1);

        // ack while idle must be ignored
        bus.bus_ack = 1'b1;
        cyc(); #1;
        chk("idle_ack_req", 32'(bus.bus_req), 32'd0);
        chk("idle_ack_di",  32'(bus.di), 32'h5A);
        bus.bus_ack = 1'b0;
        cyc();

        // I/O write, immediate ack; di unchanged
        access(1'b1, 1'b1, 16'h00FE, 8'hC3, 1, 8'h99, waits, errs);
        chk("wr_waits", 32'(waits), 32'd2);
        chk("wr_di",    32'(bus.di), 32'h5A);
        chk("wr_req",   32'(bus.bus_req), 32'd0);
        strobes_idle();
        cyc();

        // interrupt acknowledge
        bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        #1;
        chk("inta_wait_n", 32'(bus.wait_n), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            cyc(); #1;
            chk("inta_wait", 32'(bus.wait_n),  32'd1);
            chk("inta_di",   32'(bus.di),      32'hE7);
            chk("inta_req",  32'(bus.bus_req), 32'd0);
        end
        strobes_idle();
        cyc(); cyc();

        // timeout: no ack, err at N+6
        access(1'b0, 1'b0, 16'hBEEF, 8'h00, 0, 8'h11, waits, errs);
        chk("tmo_waits", 32'(waits), 32'd6);
        chk("tmo_err",   32'(bus.err), 32'd1);
        chk("tmo_errs",  32'(errs), 32'd1);
        chk("tmo_di",    32'(bus.di), 32'hFF);
        chk("tmo_req",   32'(bus.bus_req), 32'd0);
        bus.bus_rdata = 8'h22;
        bus.bus_ack   = 1'b1;
        cyc(); #1;
        chk("tmo_err_once", 32'(bus.err), 32'd0);
        chk("tmo_late_di",  32'(bus.di), 32'hFF);
        chk("tmo_late_wait", 32'(bus.wait_n), 32'd1);
        bus.bus_ack = 1'b0;
        strobes_idle();
        cyc(); cyc();

        // refresh cycle ignored
        bus.mreq_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rfsh_wait", 32'(bus.wait_n), 32'd1);
            chk("rfsh_req",  32'(bus.bus_req), 32'd0);
            cyc();
        end
        strobes_idle();
        cyc();

        // reset in BUSY with read strobe held through release
        bus.A = 16'h4321; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
        cyc(); #1;
        chk("rb_busy_req", 32'(bus.bus_req), 32'd1);
        reset = 1'b1;
        bus.bus_ack = 1'b1;
        cyc(); #1;
        chk("rb_req",  32'(bus.bus_req),  32'd0);
        chk("rb_wait", 32'(bus.wait_n),   32'd1);
        chk("rb_di",   32'(bus.di),       32'h00);
        chk("rb_addr", 32'(bus.bus_addr), 32'h0);
        bus.bus_ack = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("rb_held_wait", 32'(bus.wait_n), 32'd1);
            chk("rb_held_req",  32'(bus.bus_req), 32'd0);
        end
        strobes_idle();
        cyc();
        access(1'b0, 1'b0, 16'h4321, 8'h00, 2, 8'h3C, waits, errs);
        chk("rb_new_waits", 32'(waits), 32'd3);
        chk("rb_new_di",    32'(bus.di), 32'h3C);
        strobes_idle();
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/z80_bus_target.md
# z80_bus_target

Synchronous Z80 bus responder on the target side of the CPU bus. It decodes registered `mreq_n`/`iorq_n`/`rd_n`/`wr_n`/`m1_n` strobes into single-transaction requests on a simple req/ack backend port. It stretches the CPU cycle with `wait_n` until the backend answers, then presents read data on `di`. It also answers interrupt-acknowledge cycles with a fixed vector and bounds every access with a timeout.

## Interface
- `INT_VECTOR`, 8'hFF: byte returned on `di` during interrupt acknowledge (`m1_n`=0 and `iorq_n`=0).
- `TIMEOUT`, 255: maximum cycles in BUSY before forced completion. 0 disables the timeout. Counter width is 8 bits; legal range is 0–255.
- `clk`  in  1  system clock, same clock as the CPU core; all strobes are sampled on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`  in  1 each  CPU bus strobes.
- `A`  in  16  CPU address.
- `dout`  in  8  CPU write data.
- `wait_n`  out  1  wait request to CPU; 0 = stretch cycle.
- `di`  out  8  read data / vector to CPU.
- `bus_req`  out  1  backend request, level-held until ack.
- `bus_we`  out  1  1 = write, 0 = read.
- `bus_io`  out  1  1 = I/O space, 0 = memory space.
- `bus_addr`  out  16  latched address.
- `bus_wdata`  out  8  latched write data.
- `bus_ack`  in  1  backend completion; sampled only while `bus_req`=1.
- `bus_rdata`  in  8  backend read data, valid with `bus_ack`.
- `err`  out  1  one-cycle pulse on timeout.

## Operation
Strobe qualifiers:
- `act` = (`rd_n`=0 or `wr_n`=0) and (`mreq_n`=0 or `iorq_n`=0).
- `inta` = `m1_n`=0 and `iorq_n`=0.
- `strobe` = `act` or `inta`.
- Refresh cycles (`mreq_n`=0, `rd_n`=`wr_n`=1) are ignored.

A register `prev` holds last cycle's `strobe`. A new access `start` = `strobe` and not `prev`, qualified by state IDLE.

States:
- IDLE: on `start` with `inta`:
  - load `di`←`INT_VECTOR`; go to DONE.
- IDLE: on `start` otherwise:
  - latch `bus_addr`←`A`, `bus_wdata`←`dout`, `bus_we`←~`wr_n`, `bus_io`←~`iorq_n`;
  - set `bus_req`=1; clear the timeout counter; go to BUSY.
- BUSY, `bus_ack`=1:
  - `di`←`bus_rdata` for reads; unchanged for writes;
  - `bus_req`←0; go to DONE, or to IDLE if `strobe`=0 (abandoned access, result discarded).
- BUSY, no ack, counter = `TIMEOUT` (and `TIMEOUT`≠0):
  - `di`←8'hFF; `bus_req`←0; pulse `err`; go to DONE (or IDLE if `strobe`=0).
- BUSY, no ack otherwise: increment the counter.
- DONE: remain while `strobe`=1; go to IDLE when `strobe`=0.

`wait_n` is combinational:
- 0 when (IDLE and `start`) or (BUSY and `strobe`);
- 1 otherwise, including all of DONE.

`di` holds its last value outside DONE. It must be stable for the whole of DONE.

If `strobe` drops while in BUSY without ack, `bus_req` stays high until ack or timeout, then the block returns to IDLE. A backend transaction is never cut short.

## Timing
- Reset values:
  - `wait_n`=1, `di`=8'h00, `bus_req`=0, `bus_we`=0, `bus_io`=0, `bus_addr`=0, `bus_wdata`=0, `err`=0;
  - state IDLE, counter 0.
  - `prev`=1, so an access already in flight at reset release is ignored until its strobes deassert.
- Cycle N, detection cycle: `wait_n`=0 combinationally.
- Cycle N+1: `bus_req`=1, latched fields valid, `wait_n`=0.
- Ack sampled at cycle M ≥ N+1. At cycle M+1: state DONE, `wait_n`=1, `di` valid, `bus_req`=0.
  - Minimum CPU stretch: 2 cycles (ack at N+1).
- Interrupt acknowledge: exactly 1 wait cycle (N); DONE with vector at N+1.
- Timeout: with no ack, `err`=1 and `wait_n`=1 at cycle N+1+`TIMEOUT`+1.
- `bus_ack` while `bus_req`=0 is ignored.
- Back-to-back CPU cycles require at least one cycle of `strobe`=0 between accesses; this is guaranteed by the CPU's T1 state.
- Reset asserted mid-BUSY: at the next edge `bus_req`=0, `wait_n`=1, state IDLE; any pending ack is ignored.

## Test plan
- Memory read, ack on the 3rd BUSY cycle with rdata 8'h5A, `A`=16'h1234:
  - `bus_req`=1, `bus_io`=0, `bus_we`=0, `bus_addr`=16'h1234;
  - `wait_n` low for 4 cycles, then high with `di`=8'h5A.
- I/O write, `A`=16'h00FE, `dout`=8'hC3, immediate ack:
  - `bus_io`=1, `bus_we`=1, `bus_wdata`=8'hC3;
  - `wait_n` low for exactly 2 cycles; `di` unchanged.
- Interrupt acknowledge with `INT_VECTOR`=8'hE7:
  - no `bus_req`; `wait_n` low 1 cycle; `di`=8'hE7 until strobes drop.
- `TIMEOUT`=4, backend never acks:
  - `err` pulses once at cycle N+6; `di`=8'hFF; `wait_n` high from that cycle.
  - Ack arriving later is ignored.
- Refresh cycle (`mreq_n`=0, `rfsh_n` low, `rd_n`=`wr_n`=1):
  - `bus_req` stays 0 and `wait_n` stays 1.
- `reset` pulsed while BUSY, and again with a read strobe held through release:
  - outputs return to reset values;
  - no new `bus_req` until strobes deassert and reassert.
